// File: rtl/shift_unit.sv
// Multi-cycle shifter: SLL, SRL, SRA and ROTL by a runtime amount, at most STEP bits per clock.
// The operands are captured on the accepting edge, and the result stays in data_out until the next result.
module shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRL  = 2'b01;
    localparam logic [1:0] MODE_SRA  = 2'b10;
    localparam logic [1:0] MODE_ROTL = 2'b11;

    // One extra bit so that STEP == WIDTH can be represented.
    localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

    state_t               state_reg;
    logic [WIDTH-1:0]     work_reg;
    logic [WIDTH-1:0]     work_next;
    logic [SHAMT_W-1:0]   rem_reg;
    logic [SHAMT_W-1:0]   rem_next;
    logic [SHAMT_W-1:0]   k;
    logic [1:0]           mode_reg;
    logic                 sign_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [WIDTH-1:0]     data_out_reg;
    logic [2*WIDTH-1:0]   rot_dbl;
    logic [2*WIDTH-1:0]   sra_dbl;

    always_comb begin
        k = ({1'b0, rem_reg} > STEP_W) ? STEP_W[SHAMT_W-1:0] : rem_reg;
        rem_next = rem_reg - k;
        // Double-width shifts handle the rotate wrap-around and the sign fill.
        // They also stay well defined when k is 0.
        rot_dbl = {work_reg, work_reg} << k;
        sra_dbl = {{WIDTH{sign_reg}}, work_reg} >> k;
        work_next = work_reg;
        case (mode_reg)
            MODE_SLL:  work_next = work_reg << k;
            MODE_SRL:  work_next = work_reg >> k;
            MODE_SRA:  work_next = sra_dbl[WIDTH-1:0];
            MODE_ROTL: work_next = rot_dbl[2*WIDTH-1:WIDTH];
            default:   work_next = work_reg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            work_reg     <= '0;
            rem_reg      <= '0;
            mode_reg     <= MODE_SLL;
            sign_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            data_out_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        work_reg  <= data_in;
                        rem_reg   <= shamt;
                        mode_reg  <= mode;
                        sign_reg  <= data_in[WIDTH-1];
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    work_reg <= work_next;
                    rem_reg  <= rem_next;
                    if (rem_next == '0) begin
                        data_out_reg <= work_next;
                        done_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
                        state_reg    <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign data_out = data_out_reg;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: five instances with different STEP values, one exercised at a time.
// Expected result and latency are queued at acceptance and checked when done pulses.
module tb_shift_unit;

    localparam int NI = 5;

    function automatic int step_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 32;
        endcase
    endfunction

    typedef struct {
        logic [31:0] exp;
        int          cyc;
        int          lat;
    } sb_t;

    logic          clock;
    logic          reset;
    logic [NI-1:0] start_v;
    logic [1:0]    mode;
    logic [31:0]   data_in;
    logic [4:0]    shamt;
    logic [NI-1:0] busy_v;
    logic [NI-1:0] done_v;
    logic [31:0]   data_out_v [NI];

    sb_t  q[$];
    sb_t  e;
    int   sel;
    int   cyc;
    int   n_checks;
    int   n_pass;
    logic prev_done;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            shift_unit #(
                .WIDTH(32),
                .SHAMT_W(5),
                .STEP(step_of(gi))
            ) u_dut (
                .clock   (clock),
                .reset   (reset),
                .start   (start_v[gi]),
                .mode    (mode),
                .data_in (data_in),
                .shamt   (shamt),
                .busy    (busy_v[gi]),
                .done    (done_v[gi]),
                .data_out(data_out_v[gi])
            );
        end
    endgenerate

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s);
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $unsigned($signed(d) >>> s);
            default: return (s == 5'd0) ? d : ((d << s) | (d >> (32 - int'(s))));
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] s, input int st);
        return (s == 5'd0) ? 1 : (int'(s) + st - 1) / st;
    endfunction

    // Monitor: pops the scoreboard on each done pulse of the selected instance.
    always @(negedge clock) begin
        if (!reset) begin
            if (done_v[sel]) begin
                check_eq("done_busy_low", 32'(busy_v[sel]), 32'd0);
                check_eq("done_one_cycle", 32'(prev_done), 32'd0);
                if (q.size() == 0) begin
                    check_eq("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check_eq("data_out", data_out_v[sel], e.exp);
                    check_eq("latency", 32'(cyc - e.cyc), 32'(e.lat));
                    $display("op inst=%0d data_out=0x%08h exp=0x%08h lat=%0d", sel, data_out_v[sel], e.exp, cyc - e.cyc);
                end
            end
            prev_done = done_v[sel];
        end
    end

    task automatic issue(input int idx, input logic [1:0] m, input logic [31:0] d, input logic [4:0] s);
        sel = idx;
        @(negedge clock);
        mode = m; data_in = d; shamt = s; start_v[idx] = 1'b1;
        @(negedge clock);
        start_v[idx] = 1'b0;
        q.push_back('{exp: ref_op(m, d, s), cyc: cyc, lat: lat_of(s, step_of(idx))});
        check_eq("busy_after_accept", 32'(busy_v[idx]), 32'd1);
        // Inputs changing after acceptance must not matter.
        data_in = ~d; mode = ~m; shamt = ~s;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && q.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (q.size() != 0) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            q.delete();
        end
    endtask

    task automatic run(input int idx, input logic [1:0] m, input logic [31:0] d, input logic [4:0] s);
        issue(idx, m, d, s);
        wait_done();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; sel = 0; prev_done = 1'b0;
        reset = 1'b1; start_v = '0; mode = 2'b00; data_in = '0; shamt = '0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            check_eq("reset_busy", 32'(busy_v[i]), 32'd0);
            check_eq("reset_done", 32'(done_v[i]), 32'd0);
            check_eq("reset_data_out", data_out_v[i], 32'd0);
        end
        reset = 1'b0;

        run(0, 2'b00, 32'h0000_0001, 5'd2);
        run(2, 2'b10, 32'h8000_0000, 5'd31);
        run(2, 2'b01, 32'h8000_0000, 5'd31);
        run(0, 2'b11, 32'h8000_0001, 5'd1);
        for (int m = 0; m < 4; m++) run(0, 2'(m), 32'hDEAD_BEEF, 5'd0);
        run(4, 2'b10, 32'h8765_4321, 5'd17);

        // Held start: only the first request counts, then back-to-back from DONE.
        sel = 0;
        @(negedge clock);
        mode = 2'b00; data_in = 32'h1; shamt = 5'd5; start_v[0] = 1'b1;
        @(negedge clock);
        q.push_back('{exp: 32'h20, cyc: cyc, lat: 5});
        for (int i = 0; i < 40; i++) begin
            #1;
            if (done_v[0]) begin
                mode = 2'b00; data_in = 32'h3; shamt = 5'd5;
                break;
            end
            data_in = $urandom; mode = 2'($urandom); shamt = 5'($urandom);
            @(negedge clock);
        end
        @(negedge clock);
        check_eq("back_to_back_busy", 32'(busy_v[0]), 32'd1);
        q.push_back('{exp: 32'h60, cyc: cyc, lat: 5});
        start_v[0] = 1'b0;
        wait_done();

        // Asynchronous reset in the middle of a shift.
        run(0, 2'b00, 32'h0000_1234, 5'd3);
        issue(0, 2'b01, 32'hFFFF_FFFF, 5'd20);
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_busy", 32'(busy_v[0]), 32'd0);
        check_eq("async_rst_done", 32'(done_v[0]), 32'd0);
        check_eq("async_rst_data_out", data_out_v[0], 32'd0);
        q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run(0, 2'b01, 32'hFFFF_FFFF, 5'd20);

        // Randomised sweep over the STEP values 1, 2, 8 and 32.
        for (int idx = 0; idx < NI; idx++) begin
            if (idx == 2) continue;
            for (int n = 0; n < 16; n++)
                run(idx, 2'($urandom), $urandom, 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
